// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    localparam int unsigned StatWidth    = 32;
    localparam int unsigned StatTmoWidth = 16;

    // Bits needed to hold a counter value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Round-robin winner search: first valid requester after i_last_id, wrapping.
module uart_arb_rr_pick #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_req_valid,
    input  logic [IdW-1:0]    i_last_id,
    output logic              o_any,
    output logic [IdW-1:0]    o_winner_id
);

    // Distance from last_id+1 decides priority; smallest valid distance wins.
    always_comb begin
        int unsigned v_best;
        int unsigned v_dist;
        o_any       = 1'b0;
        o_winner_id = '0;
        v_best      = NumReq;
        v_dist      = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            v_dist = (i + NumReq - 32'(i_last_id) - 1) % NumReq;
            if (i_req_valid[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                o_any       = 1'b1;
                o_winner_id = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NumReq byte-stream requesters.
// Grant is held until packet end, MaxBurst bytes, or an inter-byte timeout.
// Optional statistics ports are enabled by defining UART_ARB_STATS_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned MaxBurst      = 16,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdW          = $clog2(NumReq)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NumReq-1:0]    i_req_valid,
    input  logic [NumReq*8-1:0]  i_req_data,
    input  logic [NumReq-1:0]    i_req_last,
    output logic [NumReq-1:0]    o_req_ready,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_grant_valid,
    output logic [IdW-1:0]       o_grant_id
`ifdef UART_ARB_STATS_EN
    ,
    output logic [NumReq*StatWidth-1:0] o_stat_bytes,
    output logic [StatTmoWidth-1:0]     o_stat_tmo
`endif
);

    localparam int unsigned BeatW = cnt_width(MaxBurst);
    localparam int unsigned IdleW = cnt_width(TimeoutCycles);

    arb_state_e       r_state, w_state_nxt;
    logic [IdW-1:0]   r_grant_id, w_grant_id_nxt;
    logic [IdW-1:0]   r_last_id, w_last_id_nxt;
    logic [BeatW-1:0] r_beat_cnt, w_beat_nxt, w_beat_inc;
    logic [IdleW-1:0] r_idle_cnt, w_idle_nxt;

    logic             w_any;
    logic [IdW-1:0]   w_winner;
    logic             w_burst, w_gvalid, w_glast, w_hs, w_tmo, w_release;

    uart_arb_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .i_req_valid (i_req_valid),
        .i_last_id   (r_last_id),
        .o_any       (w_any),
        .o_winner_id (w_winner)
    );

    assign w_burst    = (r_state == StBurst);
    assign w_gvalid   = i_req_valid[r_grant_id];
    assign w_glast    = i_req_last[r_grant_id];
    assign w_hs       = w_burst & w_gvalid & i_tx_ready;
    assign w_beat_inc = r_beat_cnt + BeatW'(1);

    // Zero-latency passthrough from the owning requester while in burst.
    assign o_grant_valid = w_burst;
    assign o_grant_id    = r_grant_id;
    assign o_tx_valid    = w_burst & w_gvalid;
    assign o_tx_data     = i_req_data[{r_grant_id, 3'b000} +: 8];

    // Only the owner sees the UART ready.
    always_comb begin
        o_req_ready = '0;
        if (w_burst) begin
            o_req_ready[r_grant_id] = i_tx_ready;
        end
    end

    // Next-state: arbitrate in idle, count beats/idle cycles and release in burst.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_last_id_nxt  = r_last_id;
        w_beat_nxt     = r_beat_cnt;
        w_idle_nxt     = r_idle_cnt;
        w_tmo          = 1'b0;
        w_release      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt    = StBurst;
                    w_grant_id_nxt = w_winner;
                end
            end
            StBurst: begin
                if (w_hs) begin
                    w_beat_nxt = w_beat_inc;
                end
                // Backpressure with valid high is not idleness.
                w_idle_nxt = w_gvalid ? '0 : r_idle_cnt + IdleW'(1);
                w_tmo      = !w_gvalid && (r_idle_cnt == IdleW'(TimeoutCycles - 1));
                w_release  = (w_hs && (w_glast || (w_beat_inc == BeatW'(MaxBurst)))) || w_tmo;
                if (w_release) begin
                    w_state_nxt   = StIdle;
                    w_last_id_nxt = r_grant_id;
                    w_beat_nxt    = '0;
                    w_idle_nxt    = '0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and counter registers; last_id resets so requester 0 wins first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_grant_id <= '0;
            r_last_id  <= IdW'(NumReq - 1);
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_last_id  <= w_last_id_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [NumReq*StatWidth-1:0] r_stat_bytes;
    logic [StatTmoWidth-1:0]     r_stat_tmo;

    // Per-requester byte counts wrap; timeout count saturates.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_bytes <= '0;
            r_stat_tmo   <= '0;
        end else begin
            if (w_hs) begin
                r_stat_bytes[{r_grant_id, 5'b00000} +: StatWidth] <=
                    r_stat_bytes[{r_grant_id, 5'b00000} +: StatWidth] + StatWidth'(1);
            end
            if (w_tmo && (r_stat_tmo != '1)) begin
                r_stat_tmo <= r_stat_tmo + StatTmoWidth'(1);
            end
        end
    end

    assign o_stat_bytes = r_stat_bytes;
    assign o_stat_tmo   = r_stat_tmo;
`endif

endmodule
